uart_rx_fsm: RTL and testbench

//  Control FSM for the UART receiver: detects the start bit and sequences one frame
//  (start, 8 data, optional parity, stop) through the edge/bit counter.

---
 rtl/uart_rx_fsm.sv | 126 ++++++++++++
 tb/tb_uart_rx_fsm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: detects the start bit, sequences one frame through the
// external edge/bit counter and decodes per-bit strobes plus the final data_valid pulse.
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic [5:0] Prescale,
   input  logic [5:0] edge_cnt,
   input  logic [7:0] bit_cnt,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_err,
   output logic       cnt_enable,
   output logic       dat_samp_en,
   output logic       strt_chk_en,
   output logic       deser_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       data_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      ERR_CHK
   } state_t;

   state_t state_reg, state_next;
   logic   par_en_q, par_en_next;
   logic   bit_end;

   assign bit_end = (edge_cnt == (Prescale - 6'd1));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_reg <= IDLE;
         par_en_q  <= 1'b0;
      end else begin
         state_reg <= state_next;
         par_en_q  <= par_en_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      par_en_next = par_en_q;
      cnt_enable  = 1'b0;
      dat_samp_en = 1'b0;
      strt_chk_en = 1'b0;
      deser_en    = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      data_valid  = 1'b0;
      busy        = 1'b1;

      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (!RX_IN) begin
               state_next  = START;
               par_en_next = PAR_EN;
            end
         end

         START: begin
            cnt_enable  = 1'b1;
            dat_samp_en = 1'b1;
            strt_chk_en = 1'b1;
            if (bit_end && (bit_cnt == 8'd0)) begin
               state_next = strt_glitch ? IDLE : DATA;
            end
         end

         DATA: begin
            cnt_enable  = 1'b1;
            dat_samp_en = 1'b1;
            deser_en    = bit_end;
            if (bit_end && (bit_cnt == 8'(DATA_WIDTH))) begin
               state_next = par_en_q ? PARITY : STOP;
            end
         end

         PARITY: begin
            cnt_enable  = 1'b1;
            dat_samp_en = 1'b1;
            par_chk_en  = bit_end;
            if (bit_end) begin
               state_next = STOP;
            end
         end

         STOP: begin
            cnt_enable  = 1'b1;
            dat_samp_en = 1'b1;
            stp_chk_en  = bit_end;
            if (bit_end) begin
               state_next = ERR_CHK;
            end
         end

         ERR_CHK: begin
            // Counter is released here so a back-to-back START finds it cleared.
            data_valid = !stp_err && !(par_en_q && par_err);
            if (!RX_IN) begin
               state_next  = START;
               par_en_next = PAR_EN;
            end else begin
               state_next = IDLE;
            end
         end

         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a behavioural edge/bit counter plus a timeline model that
// predicts the cycle of every strobe and the busy window of each frame.
module tb_uart_rx_fsm;

   localparam int MAXC = 16384;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [5:0] edge_cnt = 6'd0;
   logic [7:0] bit_cnt = 8'd0;
   logic       strt_glitch = 1'b0;
   logic       par_err = 1'b0;
   logic       stp_err = 1'b0;
   logic       cnt_enable, dat_samp_en, strt_chk_en, deser_en;
   logic       par_chk_en, stp_chk_en, data_valid, busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int chk_from = 0;

   bit exp_busy [MAXC];
   bit act_busy [MAXC];
   bit act_any  [MAXC];
   int exp_strt[$], exp_deser[$], exp_par[$], exp_stp[$], exp_dv[$];
   int act_strt[$], act_deser[$], act_par[$], act_stp[$], act_dv[$];

   uart_rx_fsm #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
      .par_err(par_err), .stp_err(stp_err), .cnt_enable(cnt_enable),
      .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en), .deser_en(deser_en),
      .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Edge/bit counter as the receiver datapath would implement it
   always @(posedge CLK) begin
      if (!cnt_enable) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= 8'd0;
      end else if (edge_cnt == Prescale - 6'd1) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= bit_cnt + 8'd1;
      end else begin
         edge_cnt <= edge_cnt + 6'd1;
      end
   end

   always @(negedge CLK) begin
      if (cyc < MAXC) begin
         act_busy[cyc] = busy;
         act_any[cyc]  = |{cnt_enable, dat_samp_en, strt_chk_en, deser_en,
                           par_chk_en, stp_chk_en, data_valid, busy};
      end
      if (strt_chk_en) act_strt.push_back(cyc);
      if (deser_en)    act_deser.push_back(cyc);
      if (par_chk_en)  act_par.push_back(cyc);
      if (stp_chk_en)  act_stp.push_back(cyc);
      if (data_valid)  act_dv.push_back(cyc);
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic cmp(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_q(input string tag, input int e[$], input int a[$]);
      cmp({tag, "_count"}, a.size(), e.size());
      for (int i = 0; i < e.size() && i < a.size(); i++) cmp({tag, "_cycle"}, a[i], e[i]);
   endtask

   task automatic check_all(input string tag);
      int bad;
      bad = 0;
      cmp_q({tag, ".strt_chk_en"}, exp_strt, act_strt);
      cmp_q({tag, ".deser_en"}, exp_deser, act_deser);
      cmp_q({tag, ".par_chk_en"}, exp_par, act_par);
      cmp_q({tag, ".stp_chk_en"}, exp_stp, act_stp);
      cmp_q({tag, ".data_valid"}, exp_dv, act_dv);
      exp_strt.delete(); exp_deser.delete(); exp_par.delete(); exp_stp.delete(); exp_dv.delete();
      act_strt.delete(); act_deser.delete(); act_par.delete(); act_stp.delete(); act_dv.delete();
      for (int c = chk_from; c < cyc && c < MAXC; c++) begin
         if ((act_busy[c] != exp_busy[c]) || (!exp_busy[c] && act_any[c])) bad++;
      end
      cmp({tag, ".busy_bad_cycles"}, bad, 0);
      chk_from = cyc;
   endtask

   // Starts a frame in the current cycle (line must be in IDLE or ERR_CHK) and returns
   // in the cycle after the frame: the IDLE cycle after a glitch, or the ERR_CHK cycle.
   task automatic run_frame(input int p, input bit par, input bit gl, input bit pe, input bit se);
      int t0, tend;
      Prescale = 6'(p);
      RX_IN    = 1'b0;
      PAR_EN   = par;
      t0       = cyc + 1;
      tend     = gl ? (t0 + p) : (t0 + (10 + int'(par)) * p);
      if (tend >= MAXC - 8) begin
         $display("FAIL cycle_budget observed=%0d expected<%0d", tend, MAXC - 8);
         $fatal(1, "cycle budget exhausted");
      end
      for (int c = t0; c < t0 + p; c++) exp_strt.push_back(c);
      if (gl) begin
         for (int c = t0; c < tend; c++) exp_busy[c] = 1'b1;
      end else begin
         for (int c = t0; c <= tend; c++) exp_busy[c] = 1'b1;
         for (int k = 1; k <= 8; k++) exp_deser.push_back(t0 + k * p + p - 1);
         if (par) exp_par.push_back(t0 + 10 * p - 1);
         exp_stp.push_back(t0 + (10 + int'(par)) * p - 1);
         if (!(se || (par && pe))) exp_dv.push_back(tend);
      end
      while (cyc < tend) begin
         step();
         if (cyc == t0) begin
            strt_glitch = gl;
            par_err     = pe;
            stp_err     = se;
         end
         if (cyc < tend) begin
            RX_IN  = 1'($urandom);
            PAR_EN = 1'($urandom);
         end
      end
      RX_IN = 1'b1;
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int t0, p, gap;
      bit par, gl, pe, se;

      // Reset state
      RST = 1'b0;
      idle(3);
      RST = 1'b1;
      cmp("reset.outputs", int'({cnt_enable, dat_samp_en, strt_chk_en, deser_en,
                                 par_chk_en, stp_chk_en, data_valid, busy}), 0);
      idle(2);
      act_strt.delete(); act_deser.delete(); act_par.delete(); act_stp.delete(); act_dv.delete();
      chk_from = cyc;

      // 1: plain frame, no parity
      run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      check_all("t1_noparity");

      // 2: parity frame, no errors
      run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      check_all("t2_parity");

      // 3: start glitch
      run_frame(8, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      check_all("t3_glitch");

      // 4: parity error, stop error, parity error ignored without parity
      run_frame(8, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(2);
      run_frame(8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      run_frame(8, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      check_all("t4_errors");

      // 5: reset at clock 30 of a frame, then a clean frame
      Prescale = 6'd8;
      RX_IN    = 1'b0;
      PAR_EN   = 1'b0;
      t0       = cyc + 1;
      for (int c = t0; c <= t0 + 30; c++) exp_busy[c] = 1'b1;
      for (int c = t0; c < t0 + 8; c++) exp_strt.push_back(c);
      exp_deser.push_back(t0 + 15);
      exp_deser.push_back(t0 + 23);
      while (cyc < t0 + 30) begin
         step();
         RX_IN = 1'($urandom);
      end
      RST = 1'b0;
      step();
      RST   = 1'b1;
      RX_IN = 1'b1;
      cmp("t5_reset_midframe.outputs", int'({cnt_enable, dat_samp_en, strt_chk_en, deser_en,
                                            par_chk_en, stp_chk_en, data_valid, busy}), 0);
      idle(2);
      run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      check_all("t5_reset");

      // 6: back-to-back frames, Prescale 8 then 16
      run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      cmp("t6_b2b8.dv_spacing", (act_dv.size() == 2) ? act_dv[1] - act_dv[0] : -1, 81);
      check_all("t6_b2b8");
      run_frame(16, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(16, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      cmp("t6_b2b16.dv_spacing", (act_dv.size() == 2) ? act_dv[1] - act_dv[0] : -1, 161);
      check_all("t6_b2b16");

      // Randomized frames: prescale, parity, glitches, errors, chaining
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 2))
            0:       p = 8;
            1:       p = 16;
            default: p = 32;
         endcase
         par = 1'($urandom);
         gl  = ($urandom_range(0, 5) == 0);
         pe  = ($urandom_range(0, 3) == 0);
         se  = ($urandom_range(0, 4) == 0);
         gap = $urandom_range(0, 3);
         if (gap != 0) idle(gap);
         run_frame(p, par, gl, pe, se);
         $display("frame %0d: prescale=%0d par=%0d glitch=%0d par_err=%0d stp_err=%0d gap=%0d",
                  i, p, par, gl, pe, se, gap);
      end
      idle(3);
      check_all("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
